// File: rtl/eth_rx_pkg.sv
// Shared widths and write-side state encoding for the RX store-and-forward frame FIFO.
package eth_rx_pkg;

    localparam int AXIS_DATA_W  = 64;
    localparam int AXIS_KEEP_W  = 8;
    localparam int FIFO_ENTRY_W = 1 + AXIS_KEEP_W + AXIS_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

endpackage

// File: rtl/eth_rx_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module eth_rx_fifo_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 73
) (
    input  logic                  clk156,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk156) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward AXIS frame FIFO: only complete, error-free frames are released;
// bad or overflowing frames are rolled back to the last commit point.
module eth_rx_frame_fifo
    import eth_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                   clk156,
    input  logic                   rst_n,
    output logic                   s_axis_rx_tready,
    input  logic                   s_axis_rx_tvalid,
    input  logic [AXIS_DATA_W-1:0] s_axis_rx_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_rx_tkeep,
    input  logic                   s_axis_rx_tlast,
    input  logic                   s_axis_rx_tuser,
    input  logic                   m_axis_rx_tready,
    output logic                   m_axis_rx_tvalid,
    output logic [AXIS_DATA_W-1:0] m_axis_rx_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_rx_tkeep,
    output logic                   m_axis_rx_tlast,
    output logic                   m_axis_rx_tuser,
    output logic [31:0]            stat_frames_ok,
    output logic [31:0]            stat_drop_bad,
    output logic [31:0]            stat_drop_ovf
);

    wr_state_t               state;
    logic                    tready_q;
    logic [ADDR_WIDTH:0]     wr_ptr, commit_ptr, rd_ptr, fill;
    logic                    accept, full, ram_we;
    logic                    ram_vld, avail, out_ready, load_out, ram_re;
    logic [FIFO_ENTRY_W-1:0] ram_rd_data;

    assign s_axis_rx_tready = tready_q;
    assign m_axis_rx_tuser  = 1'b0;

    assign accept = s_axis_rx_tvalid & tready_q;
    // Occupancy never exceeds the depth, so its MSB alone marks full.
    assign fill   = wr_ptr - rd_ptr;
    assign full   = fill[ADDR_WIDTH];
    assign ram_we = accept && (state != DROP) && !full;

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tready_q       <= 1'b0;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            stat_frames_ok <= '0;
            stat_drop_bad  <= '0;
            stat_drop_ovf  <= '0;
        end else begin
            tready_q <= 1'b1;
            if (accept) begin
                if (state == DROP || full) begin
                    if (s_axis_rx_tlast) begin
                        wr_ptr        <= commit_ptr;
                        stat_drop_ovf <= stat_drop_ovf + 32'd1;
                        state         <= IDLE;
                    end else begin
                        state <= DROP;
                    end
                end else if (s_axis_rx_tlast) begin
                    if (s_axis_rx_tuser) begin
                        wr_ptr        <= commit_ptr;
                        stat_drop_bad <= stat_drop_bad + 32'd1;
                    end else begin
                        wr_ptr         <= wr_ptr + 1'b1;
                        commit_ptr     <= wr_ptr + 1'b1;
                        stat_frames_ok <= stat_frames_ok + 32'd1;
                    end
                    state <= IDLE;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    state  <= WRITE;
                end
            end
        end
    end

    eth_rx_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (FIFO_ENTRY_W)
    ) u_ram (
        .clk156  (clk156),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data ({s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata}),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // RAM output acts as a prefetch slot ahead of the output register.
    assign avail     = rd_ptr != commit_ptr;
    assign out_ready = !m_axis_rx_tvalid || m_axis_rx_tready;
    assign load_out  = ram_vld && out_ready;
    assign ram_re    = avail && (!ram_vld || load_out);

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr           <= '0;
            ram_vld          <= 1'b0;
            m_axis_rx_tvalid <= 1'b0;
            m_axis_rx_tdata  <= '0;
            m_axis_rx_tkeep  <= '0;
            m_axis_rx_tlast  <= 1'b0;
        end else begin
            if (ram_re) begin
                rd_ptr  <= rd_ptr + 1'b1;
                ram_vld <= 1'b1;
            end else if (load_out) begin
                ram_vld <= 1'b0;
            end
            if (load_out) begin
                m_axis_rx_tvalid <= 1'b1;
                {m_axis_rx_tlast, m_axis_rx_tkeep, m_axis_rx_tdata} <= ram_rd_data;
            end else if (m_axis_rx_tready) begin
                m_axis_rx_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo: directed frame scenarios on a 512-deep and a
// 16-deep instance, plus a randomized run against a frame-level scoreboard.
module tb_eth_rx_frame_fifo;

    logic        clk156 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [63:0] s_tdata  = '0;
    logic [7:0]  s_tkeep  = '0;
    logic        s_tlast  = 1'b0;
    logic        s_tuser  = 1'b0;
    logic        sel4     = 1'b0;
    logic        tvalid9, tvalid4;

    logic        rand_mode = 1'b0;
    logic        rnd_bit   = 1'b0;
    logic        rdy9      = 1'b1;
    logic        rdy4      = 1'b0;
    logic        m_tready9, m_tready4;

    logic        s_tready9, m_tvalid9, m_tlast9, m_tuser9;
    logic [63:0] m_tdata9;
    logic [7:0]  m_tkeep9;
    logic [31:0] ok9, bad9, ovf9;
    logic        s_tready4, m_tvalid4, m_tlast4, m_tuser4;
    logic [63:0] m_tdata4;
    logic [7:0]  m_tkeep4;
    logic [31:0] ok4, bad4, ovf4;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          tuser_hits = 0;

    logic [72:0] rx9[$], rx4[$], exp9[$], frm[$];
    int unsigned rxcyc9[$];

    assign tvalid9   = s_tvalid & ~sel4;
    assign tvalid4   = s_tvalid & sel4;
    assign m_tready9 = rand_mode ? rnd_bit : rdy9;
    assign m_tready4 = rdy4;

    eth_rx_frame_fifo #(.ADDR_WIDTH(9)) dut9 (
        .clk156(clk156), .rst_n(rst_n), .s_axis_rx_tready(s_tready9),
        .s_axis_rx_tvalid(tvalid9), .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep),
        .s_axis_rx_tlast(s_tlast), .s_axis_rx_tuser(s_tuser), .m_axis_rx_tready(m_tready9),
        .m_axis_rx_tvalid(m_tvalid9), .m_axis_rx_tdata(m_tdata9), .m_axis_rx_tkeep(m_tkeep9),
        .m_axis_rx_tlast(m_tlast9), .m_axis_rx_tuser(m_tuser9),
        .stat_frames_ok(ok9), .stat_drop_bad(bad9), .stat_drop_ovf(ovf9)
    );

    eth_rx_frame_fifo #(.ADDR_WIDTH(4)) dut4 (
        .clk156(clk156), .rst_n(rst_n), .s_axis_rx_tready(s_tready4),
        .s_axis_rx_tvalid(tvalid4), .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep),
        .s_axis_rx_tlast(s_tlast), .s_axis_rx_tuser(s_tuser), .m_axis_rx_tready(m_tready4),
        .m_axis_rx_tvalid(m_tvalid4), .m_axis_rx_tdata(m_tdata4), .m_axis_rx_tkeep(m_tkeep4),
        .m_axis_rx_tlast(m_tlast4), .m_axis_rx_tuser(m_tuser4),
        .stat_frames_ok(ok4), .stat_drop_bad(bad4), .stat_drop_ovf(ovf4)
    );

    always #3 clk156 = ~clk156;

    always @(posedge clk156) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    always @(negedge clk156) begin
        if (rst_n && m_tvalid9 && m_tready9) begin
            rx9.push_back({m_tlast9, m_tkeep9, m_tdata9});
            rxcyc9.push_back(cyc);
        end
        if (rst_n && m_tvalid4 && m_tready4)
            rx4.push_back({m_tlast4, m_tkeep4, m_tdata4});
        if (m_tuser9 || m_tuser4)
            tuser_hits++;
    end

    function automatic int count_diff(input logic [72:0] a[$], input logic [72:0] b[$]);
        int n = 0;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk156);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
        @(posedge clk156);
        #1;
        s_tvalid = 1'b0;
    endtask

    // seq: data counts 0,1,2..; gaps: random idle cycles between beats
    task automatic send_frame(input int len, input logic bad, input bit seq, input bit gaps);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            logic [63:0] d;
            logic [7:0]  k;
            logic        l;
            if (gaps && $urandom_range(0, 2) == 0) idle(1);
            d = seq ? 64'(i) : {$urandom, $urandom};
            l = (i == len - 1);
            k = !l ? 8'hFF : seq ? 8'h0F : 8'((1 << $urandom_range(1, 8)) - 1);
            frm.push_back({l, k, d});
            drive_beat(d, k, l, l ? bad : 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic wait_rx9(input int n, input int limit);
        int b = 0;
        while (rx9.size() < n && b < limit) begin idle(1); b++; end
    endtask

    task automatic wait_rx4(input int n, input int limit);
        int b = 0;
        while (rx4.size() < n && b < limit) begin idle(1); b++; end
    endtask

    task automatic apply_reset;
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        rx9.delete(); rx4.delete(); rxcyc9.delete(); exp9.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({s_tready9, m_tvalid9, ok9, bad9, ovf9} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got tready=%0b tvalid=%0b ok=%0d bad=%0d ovf=%0d, expected all 0",
                     s_tready9, m_tvalid9, ok9, bad9, ovf9);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({s_tready9, s_tready4, m_tvalid9, m_tvalid4} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got tready9/4=%0b%0b tvalid9/4=%0b%0b, expected 11 00",
                     s_tready9, s_tready4, m_tvalid9, m_tvalid4);
        end
    endtask

    task automatic test_basic;
        apply_reset();
        sel4 = 1'b0; rand_mode = 1'b0; rdy9 = 1'b1;
        send_frame(8, 1'b0, 1'b1, 1'b0);
        idle(1);
        checks++;
        if (m_tvalid9 !== 1'b0) begin
            errors++; $display("FAIL latency_early: tvalid=%0b one edge after tlast, expected 0", m_tvalid9);
        end
        idle(1);
        checks++;
        if (m_tvalid9 !== 1'b1) begin
            errors++; $display("FAIL latency: tvalid=%0b two edges after tlast, expected 1", m_tvalid9);
        end
        wait_rx9(8, 50);
        idle(4);
        checks++;
        if (rx9.size() != 8 || count_diff(rx9, frm) != 0) begin
            errors++; $display("FAIL basic_data: got %0d beats (%0d differ), expected 8 matching",
                               rx9.size(), count_diff(rx9, frm));
        end
        checks++;
        if (rxcyc9.size() != 8 || rxcyc9[7] - rxcyc9[0] != 7) begin
            errors++; $display("FAIL basic_b2b: beats not on consecutive cycles (count %0d)", rxcyc9.size());
        end
        checks++;
        if (ok9 !== 32'd1) begin
            errors++; $display("FAIL basic_ok: stat_frames_ok=%0d expected 1", ok9);
        end
    endtask

    task automatic test_bad_frame;
        apply_reset();
        send_frame(4, 1'b1, 1'b1, 1'b0);
        send_frame(2, 1'b0, 1'b0, 1'b0);
        wait_rx9(2, 50);
        idle(10);
        checks++;
        if (rx9.size() != 2 || count_diff(rx9, frm) != 0) begin
            errors++; $display("FAIL bad_data: got %0d beats (%0d differ), expected 2 matching",
                               rx9.size(), count_diff(rx9, frm));
        end
        checks++;
        if ({ok9, bad9, ovf9} !== {32'd1, 32'd1, 32'd0}) begin
            errors++; $display("FAIL bad_stats: ok=%0d bad=%0d ovf=%0d, expected 1 1 0", ok9, bad9, ovf9);
        end
    endtask

    task automatic test_overflow;
        logic [72:0] exp_q[$];
        apply_reset();
        sel4 = 1'b1; rdy4 = 1'b0;
        send_frame(20, 1'b0, 1'b0, 1'b0);
        idle(5);
        checks++;
        if ({ovf4, ok4, m_tvalid4} !== {32'd1, 32'd0, 1'b0} || rx4.size() != 0) begin
            errors++; $display("FAIL ovf_long: ovf=%0d ok=%0d tvalid=%0b beats=%0d, expected 1 0 0 0",
                               ovf4, ok4, m_tvalid4, rx4.size());
        end
        send_frame(3, 1'b0, 1'b0, 1'b0);
        exp_q = frm;
        idle(5);
        checks++;
        if (ok4 !== 32'd1 || rx4.size() != 0) begin
            errors++; $display("FAIL ovf_hold: ok=%0d beats=%0d, expected 1 0", ok4, rx4.size());
        end
        rdy4 = 1'b1;
        wait_rx4(3, 50);
        idle(5);
        checks++;
        if (rx4.size() != 3 || count_diff(rx4, exp_q) != 0) begin
            errors++; $display("FAIL ovf_after: got %0d beats (%0d differ), expected 3 matching",
                               rx4.size(), count_diff(rx4, exp_q));
        end
    endtask

    task automatic test_back_to_back_ovf;
        logic [72:0] exp_q[$];
        apply_reset();
        sel4 = 1'b1; rdy4 = 1'b0;
        send_frame(10, 1'b0, 1'b0, 1'b0);
        exp_q = frm;
        send_frame(10, 1'b0, 1'b0, 1'b0);
        idle(5);
        checks++;
        if ({ok4, ovf4, bad4} !== {32'd1, 32'd1, 32'd0}) begin
            errors++; $display("FAIL b2b_stats: ok=%0d ovf=%0d bad=%0d, expected 1 1 0", ok4, ovf4, bad4);
        end
        rdy4 = 1'b1;
        wait_rx4(10, 60);
        idle(20);
        checks++;
        if (rx4.size() != 10 || count_diff(rx4, exp_q) != 0) begin
            errors++; $display("FAIL b2b_data: got %0d beats (%0d differ), expected 10 matching",
                               rx4.size(), count_diff(rx4, exp_q));
        end
        sel4 = 1'b0;
    endtask

    task automatic test_random;
        int ngood = 0;
        int nbad  = 0;
        apply_reset();
        sel4 = 1'b0; rand_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int   len;
            int   b;
            logic bad;
            len = $urandom_range(1, 190);
            bad = ($urandom_range(0, 3) == 0);
            // keep outstanding good beats plus this frame within depth so no overflow occurs
            b = 0;
            while (int'(exp9.size()) - int'(rx9.size()) + len > 512 && b < 5000) begin idle(1); b++; end
            send_frame(len, bad, 1'b0, 1'b1);
            if (bad) nbad++;
            else begin
                ngood++;
                foreach (frm[i]) exp9.push_back(frm[i]);
            end
        end
        wait_rx9(exp9.size(), 40000);
        idle(10);
        checks++;
        if (rx9.size() != exp9.size() || count_diff(rx9, exp9) != 0) begin
            errors++; $display("FAIL rand_data: got %0d beats (%0d differ), expected %0d matching",
                               rx9.size(), count_diff(rx9, exp9), exp9.size());
        end
        checks++;
        if ({ok9, bad9, ovf9} !== {32'(ngood), 32'(nbad), 32'd0}) begin
            errors++; $display("FAIL rand_stats: ok=%0d bad=%0d ovf=%0d, expected %0d %0d 0",
                               ok9, bad9, ovf9, ngood, nbad);
        end
        checks++;
        if (ok9 + bad9 + ovf9 !== 32'd100) begin
            errors++; $display("FAIL rand_sum: counters sum %0d, expected 100", ok9 + bad9 + ovf9);
        end
        checks++;
        if (tuser_hits != 0) begin
            errors++; $display("FAIL tuser_out: m tuser seen high %0d times, expected 0", tuser_hits);
        end
        rand_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [72:0] exp_q[$];
        apply_reset();
        sel4 = 1'b0; rdy9 = 1'b1;
        send_frame(40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_beat(64'(100 + i), 8'hFF, 1'b0, 1'b0);
        s_tvalid = 1'b1;
        #1;
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        checks++;
        if ({m_tvalid9, m_tlast9, m_tkeep9, m_tdata9} !== '0 || s_tready9 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out: tvalid=%0b data=%0h tready=%0b, expected all 0",
                               m_tvalid9, m_tdata9, s_tready9);
        end
        checks++;
        if ({ok9, bad9, ovf9} !== '0) begin
            errors++; $display("FAIL rst_mid_cnt: ok=%0d bad=%0d ovf=%0d, expected 0", ok9, bad9, ovf9);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        rx9.delete(); rxcyc9.delete();
        send_frame(5, 1'b0, 1'b0, 1'b0);
        exp_q = frm;
        wait_rx9(5, 50);
        idle(10);
        checks++;
        if (rx9.size() != 5 || count_diff(rx9, exp_q) != 0 || ok9 !== 32'd1) begin
            errors++; $display("FAIL rst_mid_next: got %0d beats (%0d differ) ok=%0d, expected 5 matching ok=1",
                               rx9.size(), count_diff(rx9, exp_q), ok9);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_frame();
        test_overflow();
        test_back_to_back_ovf();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
- Store-and-forward 64-bit AXIS frame FIFO in the clk156 (156.25 MHz) 10G Ethernet path.
- Sits directly upstream of the RX-to-TX bridge and feeds its s_axis_rx_* input.
- Releases only complete, error-free frames; discards frames flagged bad (tuser=1 on tlast) and frames that overflow the buffer.
- Input is never back-pressured; MAC-side RX cannot stall.

Parameters:
- ADDR_WIDTH, 9, log2 of FIFO depth in 64-bit words (512 words = 4 KiB; holds one 1518-byte frame plus margin).

Ports:
- clk156  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_rx_tready  out  1  constant 1 out of reset, 0 while rst_n low.
- s_axis_rx_tvalid  in  1  input beat valid.
- s_axis_rx_tdata  in  64  input data.
- s_axis_rx_tkeep  in  8  byte enables; only meaningful on tlast.
- s_axis_rx_tlast  in  1  last beat of frame.
- s_axis_rx_tuser  in  1  frame error; sampled on tlast beat only.
- m_axis_rx_tready  in  1  downstream ready.
- m_axis_rx_tvalid  out  1  output beat valid.
- m_axis_rx_tdata  out  64  output data.
- m_axis_rx_tkeep  out  8  output byte enables.
- m_axis_rx_tlast  out  1  output last beat.
- m_axis_rx_tuser  out  1  tied 0; bad frames never leave.
- stat_frames_ok  out  32  count of committed frames, wrapping.
- stat_drop_bad  out  32  count of frames dropped for tuser=1, wrapping.
- stat_drop_ovf  out  32  count of frames dropped for overflow, wrapping.

Behaviour:
- Reset (async assert, sync release): all pointers 0; m_axis_rx_tvalid/tdata/tkeep/tlast = 0; counters 0; write FSM = IDLE.
- Storage: 2^ADDR_WIDTH entries of {tlast, tkeep[7:0], tdata[63:0]} = 73 bits.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each ADDR_WIDTH+1 bits (extra wrap bit).
- FIFO full when wr_ptr - rd_ptr == 2^ADDR_WIDTH; all 2^ADDR_WIDTH entries are usable.
- Full is evaluated on registered rd_ptr. A read in the same cycle does not free space for that cycle's write.
- Beat acceptance: s_axis_rx_tvalid high with tready high.
- Write FSM IDLE/WRITE: first accepted beat moves to WRITE.
  - Each beat is written at wr_ptr, then wr_ptr++.
  - tlast with tuser=0: commit_ptr <= wr_ptr+1 (including this beat); stat_frames_ok++; go to IDLE.
  - tlast with tuser=1: wr_ptr <= commit_ptr (rollback); stat_drop_bad++; go to IDLE.
  - Single-beat frames (tlast on first beat) follow the same rules directly from IDLE.
- Write FSM DROP: entered when a beat arrives while full, from IDLE or WRITE.
  - That beat and all further beats are discarded.
  - On tlast: wr_ptr <= commit_ptr; stat_drop_ovf++ (tuser ignored; overflow wins); go to IDLE.
  - A tlast beat arriving while full goes straight to rollback and counts as overflow.
- Frames longer than 2^ADDR_WIDTH beats are always dropped as overflow.
- Read side sees only commit_ptr, so rollbacks never disturb in-progress reads. Data is available when rd_ptr != commit_ptr.
- Output is a registered stage fed by a 1-cycle-latency RAM read plus prefetch.
  - tvalid/tdata/tkeep/tlast stay stable until accepted.
  - Full throughput: 1 beat/cycle while m_axis_rx_tready=1 and data is available.
- Latency: with FIFO and output empty, m_axis_rx_tvalid rises on the 2nd rising edge after the edge that accepts a committing tlast.
- Counters increment on the edge that decides the frame outcome.
- Reset mid-frame: partial frame lost, no counter change, output deasserts immediately.

Decomposition:
- Package eth_rx_pkg: AXIS_DATA_W=64, AXIS_KEEP_W=8, FIFO_ENTRY_W=73, write-FSM state enum {IDLE, WRITE, DROP}.
- Sub-module eth_rx_fifo_ram: simple dual-port RAM, parameterised by depth and width, with one write port and a registered read port. Everything else stays in eth_rx_frame_fifo.

Test Plan:
- 8-beat frame, tdata=0x0..07, last tkeep=0x0F, tuser=0, m tready=1 -> identical 8 beats out back-to-back; tvalid 2 cycles after tlast; stat_frames_ok=1.
- 4-beat frame with tuser=1 on tlast, then a 2-beat good frame -> only the 2-beat frame emerges; stat_drop_bad=1, stat_frames_ok=1.
- ADDR_WIDTH=4, m tready=0, 20-beat frame -> nothing output; stat_drop_ovf=1. Then a 3-beat frame -> output once tready=1.
- ADDR_WIDTH=4: 10-beat frame stored, then 10-beat frame with tready=0 -> first frame intact, second dropped as overflow; after release, 10 beats out.
- Random tready (50%), 100 frames of 1–190 beats with random tuser -> output equals the scoreboard of good frames; counters sum to 100.
- rst_n pulsed low mid-frame and mid-read -> outputs 0 immediately; counters 0; next frame passes cleanly.
